// File: rtl/universal_shift_register.sv
// Multi-mode shift/rotate register with parallel load and a start/busy/done handshake.
// Each operation performs a programmable number of single-bit steps, one per clock.
module universal_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       mode_q;

    logic [WIDTH-1:0] step_q;
    logic             step_so;

    // Result of one step in the latched mode; reserved mode holds both q and ser_out.
    always_comb begin
        step_q  = q;
        step_so = ser_out;
        case (mode_q)
            3'd0: begin
                step_q  = {q[WIDTH-2:0], 1'b0};
                step_so = q[WIDTH-1];
            end
            3'd1: begin
                step_q  = {1'b0, q[WIDTH-1:1]};
                step_so = q[0];
            end
            3'd2: begin
                step_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                step_so = q[0];
            end
            3'd3: begin
                step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                step_so = q[WIDTH-1];
            end
            3'd4: begin
                step_q  = {q[0], q[WIDTH-1:1]};
                step_so = q[0];
            end
            3'd5: begin
                step_q  = {q[WIDTH-2:0], ser_in};
                step_so = q[WIDTH-1];
            end
            3'd6: begin
                step_q  = {ser_in, q[WIDTH-1:1]};
                step_so = q[0];
            end
            default: begin
                step_q  = q;
                step_so = ser_out;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= '0;
            q       <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        if (amount == '0) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            mode_q  <= mode;
                            cnt_q   <= amount;
                            busy    <= 1'b1;
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    q       <= step_q;
                    ser_out <= step_so;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    // Last step: drop busy and raise done on the same edge.
                    if (cnt_q == CNT_W'(1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed scenarios plus random operations
// compared against an arithmetic reference model.
module tb_universal_shift_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;
    int mq;   // model register value
    int mso;  // model serial-out bit

    universal_shift_register #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .d      (d),
        .start  (start),
        .mode   (mode),
        .amount (amount),
        .ser_in (ser_in),
        .q      (q),
        .ser_out(ser_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One step of the reference model, computed arithmetically on an 8-bit value.
    task automatic model_step(input int md, input int sin);
        int v;
        v = mq;
        case (md)
            0: begin mso = v / 128; mq = (v * 2) % 256; end
            1: begin mso = v % 2;   mq = v / 2; end
            2: begin mso = v % 2;   mq = v / 2 + ((v >= 128) ? 128 : 0); end
            3: begin mso = v / 128; mq = (v * 2) % 256 + v / 128; end
            4: begin mso = v % 2;   mq = v / 2 + (v % 2) * 128; end
            5: begin mso = v / 128; mq = (v * 2) % 256 + sin; end
            6: begin mso = v % 2;   mq = v / 2 + sin * 128; end
            default: begin end
        endcase
    endtask

    task automatic do_load(input int val);
        @(negedge clk);
        load = 1'b1;
        d    = WIDTH'(val);
        @(negedge clk);
        load = 1'b0;
        mq   = val;
        check("load_q", 32'(q), 32'(mq));
        check("load_busy", 32'(busy), 0);
        check("load_done", 32'(done), 0);
        check("load_ser_out_hold", 32'(ser_out), 32'(mso));
    endtask

    // sin_sel < 0 picks a random serial bit per step; noise holds load/start high past start.
    task automatic run_op(input int md, input int amt, input int sin_sel, input bit noise);
        int sin;
        @(negedge clk);
        start  = 1'b1;
        mode   = 3'(md);
        amount = CNT_W'(amt);
        @(negedge clk);
        if (noise) begin
            load = 1'b1;
            d    = 8'h33;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < amt; i++) begin
            check("op_busy", 32'(busy), 1);
            check("op_done_low", 32'(done), 0);
            sin    = (sin_sel < 0) ? int'($urandom_range(1, 0)) : sin_sel;
            ser_in = sin[0];
            mode   = 3'($urandom);
            amount = CNT_W'($urandom);
            model_step(md, sin);
            @(negedge clk);
            check("step_q", 32'(q), 32'(mq));
            check("step_ser_out", 32'(ser_out), 32'(mso));
        end
        check("fin_done", 32'(done), 1);
        check("fin_busy", 32'(busy), 0);
        check("fin_q", 32'(q), 32'(mq));
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        check("post_done_low", 32'(done), 0);
        check("post_busy_low", 32'(busy), 0);
        check("post_q", 32'(q), 32'(mq));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mq          = 0;
        mso         = 0;
        rst_n       = 1'b1;
        load        = 1'b0;
        d           = '0;
        start       = 1'b0;
        mode        = '0;
        amount      = '0;
        ser_in      = 1'b0;

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 0);
        check("rst_ser_out", 32'(ser_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotate left by 3.
        do_load(8'hB4);
        run_op(3, 3, 0, 1'b0);
        check("rol_q", 32'(q), 32'h A5);
        check("rol_ser_out", 32'(ser_out), 1);

        // Arithmetic right by 2.
        do_load(8'h90);
        run_op(2, 2, 0, 1'b0);
        check("sra_q", 32'(q), 32'h E4);
        check("sra_ser_out", 32'(ser_out), 0);

        // Zero-length operation.
        do_load(8'h5A);
        run_op(1, 0, 0, 1'b0);
        check("zero_q", 32'(q), 32'h 5A);

        // Overshift: SLL by 10 on all ones.
        do_load(8'hFF);
        run_op(0, 10, 0, 1'b0);
        check("sll10_q", 32'(q), 0);
        check("sll10_ser_out", 32'(ser_out), 0);

        // Serial-in right with load/start held during SHIFT and DONE.
        do_load(8'h00);
        run_op(6, 4, 1, 1'b1);
        check("sri_q", 32'(q), 32'h F0);
        check("sri_ser_out", 32'(ser_out), 0);

        // Reset mid-operation after 3 steps of SLL by 8.
        do_load(8'hFF);
        @(negedge clk);
        start  = 1'b1;
        mode   = 3'd0;
        amount = CNT_W'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_q_before", 32'(q), 32'h F8);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_q", 32'(q), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ser_out", 32'(ser_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq    = 0;
        mso   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mid_no_done", 32'(done), 0);
            check("mid_no_busy", 32'(busy), 0);
        end
        do_load(8'h12);
        check("mid_reload_q", 32'(q), 32'h 12);

        // Random operations against the model.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(1, 0) == 1) do_load(int'($urandom_range(255, 0)));
            run_op(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)), -1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
